// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants, colors and raw sync helper
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC - 1;

  // RRRGGGBB palette shared with draw_logic
  localparam logic [7:0] BLACK = 8'h00;
  localparam logic [7:0] RED   = 8'hE0;
  localparam logic [7:0] GREEN = 8'h1C;
  localparam logic [7:0] BLUE  = 8'h03;

  // {hs, vs, act} with syncs idle high and blanking asserted
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  function automatic logic [2:0] timing_raw(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input logic [COORD_W-1:0] hs_start,
    input logic [COORD_W-1:0] hs_end,
    input logic [COORD_W-1:0] vs_start,
    input logic [COORD_W-1:0] vs_end,
    input logic [COORD_W-1:0] h_vis,
    input logic [COORD_W-1:0] v_vis
  );
    return {~((x >= hs_start) && (x <= hs_end)),
            ~((y >= vs_start) && (y <= vs_end)),
            (x < h_vis) && (y < v_vis)};
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - tick-enabled {hs,vs,act} shift register
module sync_delay_line
  import vga_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [2:0] din_i,
  output logic [2:0] dout_o
);

  logic [2:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= SYNC_IDLE;
    end else if (en_i) begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA pixel divider, x/y counters and look-ahead-aligned sync/blank
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int LOOKAHEAD = 1,
  parameter int H_VIS     = H_ACTIVE,
  parameter int H_FRONT   = H_FP,
  parameter int H_PULSE   = H_SYNC,
  parameter int H_BACK    = H_BP,
  parameter int V_VIS     = V_ACTIVE,
  parameter int V_FRONT   = V_FP,
  parameter int V_PULSE   = V_SYNC,
  parameter int V_BACK    = V_BP
) (
  input  logic                clk,
  input  logic                rst,
  output logic                pix_tick,
  output logic [COORD_W-1:0]  next_x,
  output logic [COORD_W-1:0]  next_y,
  output logic                hsync,
  output logic                vsync,
  output logic                blank_n,
  output logic                frame_start
);

  localparam logic [2:0]         DIV_LAST = 3'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_VIS + H_FRONT + H_PULSE + H_BACK - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_VIS + V_FRONT + V_PULSE + V_BACK - 1);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VIS + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VIS + H_FRONT + H_PULSE - 1);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VIS + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VIS + V_FRONT + V_PULSE - 1);
  localparam logic [COORD_W-1:0] X_VIS    = COORD_W'(H_VIS);
  localparam logic [COORD_W-1:0] Y_VIS    = COORD_W'(V_VIS);

  logic [2:0]         div_q, div_d;
  logic               tick_q, tick_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               fs_q, fs_d;
  logic [2:0]         raw_sel, sync_out;

  always_comb begin
    div_d  = (div_q == DIV_LAST) ? 3'd0 : div_q + 3'd1;
    tick_d = (div_d == DIV_LAST);
    x_d    = x_q;
    y_d    = y_q;
    fs_d   = 1'b0;
    if (tick_q) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d  = '0;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      x_q    <= x_d;
      y_q    <= y_d;
      fs_q   <= fs_d;
    end
  end

  // Zero look-ahead registers the upcoming position; otherwise the pipe shifts in the current one
  assign raw_sel = (LOOKAHEAD == 0)
                 ? timing_raw(x_d, y_d, HS_START, HS_END, VS_START, VS_END, X_VIS, Y_VIS)
                 : timing_raw(x_q, y_q, HS_START, HS_END, VS_START, VS_END, X_VIS, Y_VIS);

  generate
    if (LOOKAHEAD == 0) begin : g_direct
      logic [2:0] out_q;
      always_ff @(posedge clk) begin
        if (rst) out_q <= SYNC_IDLE;
        else     out_q <= raw_sel;
      end
      assign sync_out = out_q;
    end else begin : g_delay
      sync_delay_line #(.DEPTH(LOOKAHEAD)) u_dly (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (tick_q),
        .din_i  (raw_sel),
        .dout_o (sync_out)
      );
    end
  endgenerate

  assign pix_tick    = tick_q;
  assign next_x      = x_q;
  assign next_y      = y_q;
  assign hsync       = sync_out[2];
  assign vsync       = sync_out[1];
  assign blank_n     = sync_out[0];
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tick_w [4];
  logic [9:0] x_w    [4];
  logic [9:0] y_w    [4];
  logic       hs_w   [4];
  logic       vs_w   [4];
  logic       bl_w   [4];
  logic       fs_w   [4];

  // 0: default, 1: CLK_DIV=1/LOOKAHEAD=0, 2: small raster, 3: small raster CLK_DIV=3/LOOKAHEAD=3
  int cd  [4] = '{2, 1, 2, 3};
  int cl  [4] = '{1, 0, 1, 3};
  int cha [4] = '{640, 640, 8, 8};
  int chf [4] = '{16, 16, 2, 2};
  int chs [4] = '{96, 96, 3, 3};
  int chb [4] = '{48, 48, 3, 3};
  int cva [4] = '{480, 480, 4, 4};
  int cvf [4] = '{10, 10, 1, 1};
  int cvs [4] = '{2, 2, 2, 2};
  int cvb [4] = '{33, 33, 1, 1};

  vga_timing_gen #(.CLK_DIV(2), .LOOKAHEAD(1)) u_a (
    .clk(clk), .rst(rst), .pix_tick(tick_w[0]), .next_x(x_w[0]), .next_y(y_w[0]),
    .hsync(hs_w[0]), .vsync(vs_w[0]), .blank_n(bl_w[0]), .frame_start(fs_w[0]));

  vga_timing_gen #(.CLK_DIV(1), .LOOKAHEAD(0)) u_b (
    .clk(clk), .rst(rst), .pix_tick(tick_w[1]), .next_x(x_w[1]), .next_y(y_w[1]),
    .hsync(hs_w[1]), .vsync(vs_w[1]), .blank_n(bl_w[1]), .frame_start(fs_w[1]));

  vga_timing_gen #(.CLK_DIV(2), .LOOKAHEAD(1), .H_VIS(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(3),
                   .V_VIS(4), .V_FRONT(1), .V_PULSE(2), .V_BACK(1)) u_c (
    .clk(clk), .rst(rst), .pix_tick(tick_w[2]), .next_x(x_w[2]), .next_y(y_w[2]),
    .hsync(hs_w[2]), .vsync(vs_w[2]), .blank_n(bl_w[2]), .frame_start(fs_w[2]));

  vga_timing_gen #(.CLK_DIV(3), .LOOKAHEAD(3), .H_VIS(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(3),
                   .V_VIS(4), .V_FRONT(1), .V_PULSE(2), .V_BACK(1)) u_d (
    .clk(clk), .rst(rst), .pix_tick(tick_w[3]), .next_x(x_w[3]), .next_y(y_w[3]),
    .hsync(hs_w[3]), .vsync(vs_w[3]), .blank_n(bl_w[3]), .frame_start(fs_w[3]));

  int n_cmp  = 0;
  int n_fail = 0;
  int tt     = 0;
  int cyc    = 0;
  bit chk_on = 0;
  bit meas_on = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Closed-form view: tt edges since reset -> ticks elapsed -> raster position -> raw timing
  function automatic logic [24:0] model(input int i, input int t);
    int d, la, ht, vt, fr, k, p, q, qx, qy;
    logic tk, fs, hs, vs, bl;
    logic [9:0] ex, ey;
    d  = cd[i];
    la = cl[i];
    ht = cha[i] + chf[i] + chs[i] + chb[i];
    vt = cva[i] + cvf[i] + cvs[i] + cvb[i];
    fr = ht * vt;
    k  = (t == 0) ? 0 : (t / d - ((d == 1) ? 1 : 0));
    tk = (t > 0) && (t % d == d - 1);
    p  = k % fr;
    ex = 10'(p % ht);
    ey = 10'(p / ht);
    fs = (t > 0) && (t % d == 0) && (k > 0) && (k % fr == 0);
    if (t == 0 || k < la) begin
      {hs, vs, bl} = 3'b110;
    end else begin
      q  = (k - la) % fr;
      qx = q % ht;
      qy = q / ht;
      hs = !(qx >= cha[i] + chf[i] && qx < cha[i] + chf[i] + chs[i]);
      vs = !(qy >= cva[i] + cvf[i] && qy < cva[i] + cvf[i] + cvs[i]);
      bl = (qx < cha[i]) && (qy < cva[i]);
    end
    return {tk, ex, ey, hs, vs, bl, fs};
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) tt = 0;
    else     tt++;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("model[%0d] {tick,x,y,hs,vs,bl,fs}", i),
              {39'd0, tick_w[i], x_w[i], y_w[i], hs_w[i], vs_w[i], bl_w[i], fs_w[i]},
              {39'd0, model(i, tt)});
      end
    end
  end

  int a_tx656 = -1, a_hf1 = -1, a_hr1 = -1, a_hf2 = -1;
  int a_tx0 = -1, a_br = -1, a_tx640 = -1, a_bf = -1;
  int b_hf = -1, b_hr = -1, b_tx0 = -1, b_br = -1;
  int c_fs1 = -1, c_fs2 = -1, c_fs_hi = 0, c_ty5 = -1, c_vf = -1, c_vr = -1;
  logic [9:0] pa_x = 0, pb_x = 0, pc_y = 0;
  logic pa_hs = 1, pa_bl = 0, pb_hs = 1, pb_bl = 0, pc_vs = 1, pc_fs = 0;

  always @(negedge clk) begin
    if (meas_on) begin
      if (x_w[0] == 656 && pa_x != 656 && a_tx656 < 0) a_tx656 = cyc;
      if (!hs_w[0] && pa_hs) begin
        if (a_hf1 < 0) a_hf1 = cyc;
        else if (a_hf2 < 0) a_hf2 = cyc;
      end
      if (hs_w[0] && !pa_hs && a_hf1 >= 0 && a_hr1 < 0) a_hr1 = cyc;
      if (x_w[0] == 0 && pa_x == 799 && a_tx0 < 0) a_tx0 = cyc;
      if (bl_w[0] && !pa_bl && a_tx0 >= 0 && a_br < 0) a_br = cyc;
      if (x_w[0] == 640 && pa_x != 640 && a_tx640 < 0) a_tx640 = cyc;
      if (!bl_w[0] && pa_bl && a_tx640 >= 0 && a_bf < 0) a_bf = cyc;

      if (!hs_w[1] && pb_hs && b_hf < 0) b_hf = cyc;
      if (hs_w[1] && !pb_hs && b_hf >= 0 && b_hr < 0) b_hr = cyc;
      if (x_w[1] == 0 && pb_x == 799 && b_tx0 < 0) b_tx0 = cyc;
      if (bl_w[1] && !pb_bl && b_tx0 >= 0 && b_br < 0) b_br = cyc;

      if (fs_w[2] && !pc_fs) begin
        if (c_fs1 < 0) c_fs1 = cyc;
        else if (c_fs2 < 0) c_fs2 = cyc;
      end
      if (fs_w[2] && c_fs2 < 0) c_fs_hi++;
      if (y_w[2] == 5 && pc_y != 5 && c_ty5 < 0) c_ty5 = cyc;
      if (!vs_w[2] && pc_vs && c_ty5 >= 0 && c_vf < 0) c_vf = cyc;
      if (vs_w[2] && !pc_vs && c_vf >= 0 && c_vr < 0) c_vr = cyc;
    end
    pa_x = x_w[0]; pa_hs = hs_w[0]; pa_bl = bl_w[0];
    pb_x = x_w[1]; pb_hs = hs_w[1]; pb_bl = bl_w[1];
    pc_y = y_w[2]; pc_vs = vs_w[2]; pc_fs = fs_w[2];
  end

  task automatic release_and_check_start(input string tag);
    rst = 1'b0;
    @(negedge clk);
    check({tag, ".a_first_tick"}, {63'd0, tick_w[0]}, 64'd1);
    check({tag, ".a_x_hold"},     {54'd0, x_w[0]},    64'd0);
    check({tag, ".b_first_tick"}, {63'd0, tick_w[1]}, 64'd1);
    @(negedge clk);
    check({tag, ".a_x_is_1"},     {54'd0, x_w[0]},    64'd1);
    check({tag, ".a_tick_low"},   {63'd0, tick_w[0]}, 64'd0);
    check({tag, ".b_x_is_1"},     {54'd0, x_w[1]},    64'd1);
  endtask

  localparam logic [24:0] IDLE = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    bit found;
    @(negedge clk);
    chk_on = 1;
    repeat (4) @(negedge clk);
    check("reset.a_state", {39'd0, tick_w[0], x_w[0], y_w[0], hs_w[0], vs_w[0], bl_w[0], fs_w[0]},
          {39'd0, IDLE});
    meas_on = 1;
    release_and_check_start("rel1");

    repeat (3700) @(negedge clk);
    meas_on = 0;
    check("a.hsync_fall_after_x656", 64'(a_hf1 - a_tx656), 64'd2);
    check("a.hsync_low_width",       64'(a_hr1 - a_hf1),   64'd192);
    check("a.hsync_period",          64'(a_hf2 - a_hf1),   64'd1600);
    check("a.blank_rise_after_wrap", 64'(a_br - a_tx0),    64'd2);
    check("a.blank_fall_after_x640", 64'(a_bf - a_tx640),  64'd2);
    check("b.hsync_low_width",       64'(b_hr - b_hf),     64'd96);
    check("b.blank_rise_same_edge",  64'(b_br - b_tx0),    64'd0);
    check("b.wrap_seen",             64'(b_tx0 >= 0),      64'd1);
    check("c.frame_start_period",    64'(c_fs2 - c_fs1),   64'd256);
    check("c.frame_start_width",     64'(c_fs_hi),         64'd1);
    check("c.vsync_fall_after_y5",   64'(c_vf - c_ty5),    64'd2);
    check("c.vsync_low_width",       64'(c_vr - c_vf),     64'd64);

    found = 0;
    for (int n = 0; n < 3000; n++) begin
      if (x_w[0] == 300 && y_w[0] == 2) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("midrst.reached_300_2", {63'd0, found}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst.a_state", {39'd0, tick_w[0], x_w[0], y_w[0], hs_w[0], vs_w[0], bl_w[0], fs_w[0]},
          {39'd0, IDLE});
    release_and_check_start("rel2");
    repeat (2000) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
